// File: rtl/pipeline_ctrl_commit.sv
// SPI command decoder with shadow registers committed to the active
// overlay/scale/offset/clip settings at the next vertical blanking.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | expecting an opcode byte
// DATA_HI | expecting the high byte of a 2-byte operand
// DATA_LO | expecting the final operand byte; shadow write on receipt
// DISCARD | unknown opcode seen, ignore bytes until cs_end
module pipeline_ctrl_commit #(
  parameter int PRECISION = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  input  logic                        cs_end,
  input  logic                        frame_start,
  output logic [1:0]                  ctrl_overlay_mode,
  output logic [1:0]                  ctrl_fg_scale,
  output logic signed [PRECISION:0]   ctrl_fg_offset_x,
  output logic signed [PRECISION:0]   ctrl_fg_offset_y,
  output logic [PRECISION-1:0]        ctrl_fg_clip_left,
  output logic [PRECISION-1:0]        ctrl_fg_clip_right,
  output logic [PRECISION-1:0]        ctrl_fg_clip_top,
  output logic [PRECISION-1:0]        ctrl_fg_clip_bottom,
  output logic [7:0]                  status
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DATA_HI = 2'd1;
  localparam logic [1:0] DATA_LO = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [7:0] OP_OVERLAY  = 8'h01;
  localparam logic [7:0] OP_SCALE    = 8'h02;
  localparam logic [7:0] OP_OFFSET_X = 8'h03;
  localparam logic [7:0] OP_OFFSET_Y = 8'h04;
  localparam logic [7:0] OP_CLIP_L   = 8'h05;
  localparam logic [7:0] OP_CLIP_R   = 8'h06;
  localparam logic [7:0] OP_CLIP_T   = 8'h07;
  localparam logic [7:0] OP_CLIP_B   = 8'h08;
  localparam logic [7:0] OP_COMMIT   = 8'h10;
  localparam logic [7:0] OP_CLR_ERR  = 8'h11;

  logic [1:0]                 state;
  logic [7:0]                 opcode;
  logic [7:0]                 data_hi;
  logic                       commit_pending;
  logic                       error_sticky;
  logic                       apply;
  logic [15:0]                data_word;

  logic [1:0]                 sh_overlay_mode;
  logic [1:0]                 sh_fg_scale;
  logic signed [PRECISION:0]  sh_offset_x;
  logic signed [PRECISION:0]  sh_offset_y;
  logic [PRECISION-1:0]       sh_clip_left;
  logic [PRECISION-1:0]       sh_clip_right;
  logic [PRECISION-1:0]       sh_clip_top;
  logic [PRECISION-1:0]       sh_clip_bottom;

  // A commit strobed in the same cycle as frame_start is not yet visible here,
  // so it waits for the following frame.
  assign apply     = frame_start && commit_pending;
  assign data_word = {data_hi, rx_data};
  assign status    = {commit_pending, error_sticky, 6'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      opcode              <= '0;
      data_hi             <= '0;
      commit_pending      <= 1'b0;
      error_sticky        <= 1'b0;
      sh_overlay_mode     <= '0;
      sh_fg_scale         <= '0;
      sh_offset_x         <= '0;
      sh_offset_y         <= '0;
      sh_clip_left        <= '0;
      sh_clip_right       <= '0;
      sh_clip_top         <= '0;
      sh_clip_bottom      <= '0;
      ctrl_overlay_mode   <= '0;
      ctrl_fg_scale       <= '0;
      ctrl_fg_offset_x    <= '0;
      ctrl_fg_offset_y    <= '0;
      ctrl_fg_clip_left   <= '0;
      ctrl_fg_clip_right  <= '0;
      ctrl_fg_clip_top    <= '0;
      ctrl_fg_clip_bottom <= '0;
    end else begin
      // Nonblocking copy picks up the pre-write shadow if a write coincides.
      if (apply) begin
        ctrl_overlay_mode   <= sh_overlay_mode;
        ctrl_fg_scale       <= sh_fg_scale;
        ctrl_fg_offset_x    <= sh_offset_x;
        ctrl_fg_offset_y    <= sh_offset_y;
        ctrl_fg_clip_left   <= sh_clip_left;
        ctrl_fg_clip_right  <= sh_clip_right;
        ctrl_fg_clip_top    <= sh_clip_top;
        ctrl_fg_clip_bottom <= sh_clip_bottom;
        commit_pending      <= 1'b0;
      end

      if (cs_end) begin
        state <= IDLE;
        if (state == DATA_HI || state == DATA_LO)
          error_sticky <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            opcode <= rx_data;
            case (rx_data)
              OP_OVERLAY, OP_SCALE:
                state <= DATA_LO;
              OP_OFFSET_X, OP_OFFSET_Y, OP_CLIP_L, OP_CLIP_R, OP_CLIP_T, OP_CLIP_B:
                state <= DATA_HI;
              OP_COMMIT:
                commit_pending <= 1'b1;
              OP_CLR_ERR:
                error_sticky <= 1'b0;
              default: begin
                error_sticky <= 1'b1;
                state        <= DISCARD;
              end
            endcase
          end
          DATA_HI: begin
            data_hi <= rx_data;
            state   <= DATA_LO;
          end
          DATA_LO: begin
            case (opcode)
              OP_OVERLAY:  sh_overlay_mode <= rx_data[1:0];
              OP_SCALE:    sh_fg_scale     <= rx_data[1:0];
              OP_OFFSET_X: sh_offset_x     <= data_word[PRECISION:0];
              OP_OFFSET_Y: sh_offset_y     <= data_word[PRECISION:0];
              OP_CLIP_L:   sh_clip_left    <= data_word[PRECISION-1:0];
              OP_CLIP_R:   sh_clip_right   <= data_word[PRECISION-1:0];
              OP_CLIP_T:   sh_clip_top     <= data_word[PRECISION-1:0];
              OP_CLIP_B:   sh_clip_bottom  <= data_word[PRECISION-1:0];
              default:     ;
            endcase
            state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl_commit.sv
// Directed bench for pipeline_ctrl_commit: expected output snapshots are queued
// as each step is driven and compared once the step has taken effect.
module tb_pipeline_ctrl_commit;

  logic               clk = 1'b0;
  logic               rst;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               cs_end;
  logic               frame_start;
  logic [1:0]         ctrl_overlay_mode;
  logic [1:0]         ctrl_fg_scale;
  logic signed [15:0] ctrl_fg_offset_x;
  logic signed [15:0] ctrl_fg_offset_y;
  logic [14:0]        ctrl_fg_clip_left;
  logic [14:0]        ctrl_fg_clip_right;
  logic [14:0]        ctrl_fg_clip_top;
  logic [14:0]        ctrl_fg_clip_bottom;
  logic [7:0]         status;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [1:0]  ov;
    logic [1:0]  sc;
    logic [15:0] ox;
    logic [15:0] oy;
    logic [14:0] cl;
    logic [14:0] cr;
    logic [14:0] ct;
    logic [14:0] cb;
    logic [7:0]  st;
  } exp_t;

  exp_t cur;
  exp_t sb[$];

  pipeline_ctrl_commit #(.PRECISION(15)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .cs_end              (cs_end),
    .frame_start         (frame_start),
    .ctrl_overlay_mode   (ctrl_overlay_mode),
    .ctrl_fg_scale       (ctrl_fg_scale),
    .ctrl_fg_offset_x    (ctrl_fg_offset_x),
    .ctrl_fg_offset_y    (ctrl_fg_offset_y),
    .ctrl_fg_clip_left   (ctrl_fg_clip_left),
    .ctrl_fg_clip_right  (ctrl_fg_clip_right),
    .ctrl_fg_clip_top    (ctrl_fg_clip_top),
    .ctrl_fg_clip_bottom (ctrl_fg_clip_bottom),
    .status              (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] st);
    exp_t e;
    e     = cur;
    e.tag = tag;
    e.st  = st;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".overlay"},   16'(ctrl_overlay_mode),   16'(e.ov));
      chk({e.tag, ".scale"},     16'(ctrl_fg_scale),       16'(e.sc));
      chk({e.tag, ".offset_x"},  ctrl_fg_offset_x,         e.ox);
      chk({e.tag, ".offset_y"},  ctrl_fg_offset_y,         e.oy);
      chk({e.tag, ".clip_l"},    16'(ctrl_fg_clip_left),   16'(e.cl));
      chk({e.tag, ".clip_r"},    16'(ctrl_fg_clip_right),  16'(e.cr));
      chk({e.tag, ".clip_t"},    16'(ctrl_fg_clip_top),    16'(e.ct));
      chk({e.tag, ".clip_b"},    16'(ctrl_fg_clip_bottom), 16'(e.cb));
      chk({e.tag, ".status"},    16'(status),              16'(e.st));
    end
  endtask

  // All drivers start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_cs();
    cs_end = 1'b1;
    @(negedge clk);
    cs_end = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; cs_end = 1'b0; frame_start = 1'b0;
    cur = '{tag: "", ov: 2'd0, sc: 2'd0, ox: 16'd0, oy: 16'd0,
            cl: 15'd0, cr: 15'd0, ct: 15'd0, cb: 15'd0, st: 8'h00};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp("reset", 8'h00);
    check_pop();

    // offset_x = 300 via 03 01 2C, commit, then frame
    push_exp("offx_pending", 8'h80);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h2C); send_byte(8'h10);
    check_pop();
    cur.ox = 16'd300;
    push_exp("offx_applied", 8'h00);
    pulse_frame();
    check_pop();

    // negative offset_y, outputs unchanged until frame
    push_exp("offy_pending", 8'h80);
    send_byte(8'h04); send_byte(8'hFF); send_byte(8'h9C); send_byte(8'h10);
    check_pop();
    cur.oy = 16'hFF9C;
    push_exp("offy_applied", 8'h00);
    pulse_frame();
    check_pop();

    // truncated command sets error, clear error, clip_right width truncation
    push_exp("partial_err", 8'h40);
    send_byte(8'h05); send_byte(8'h01); pulse_cs();
    check_pop();
    push_exp("clr_err", 8'h00);
    send_byte(8'h11);
    check_pop();
    send_byte(8'h06); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h10);
    cur.cr = 15'h7FFF;
    push_exp("clip_r_max", 8'h00);
    pulse_frame();
    check_pop();

    // unknown opcode discards the rest of the transaction
    push_exp("discard_err", 8'h40);
    send_byte(8'h7F); send_byte(8'h01); send_byte(8'h03); pulse_cs();
    check_pop();
    send_byte(8'h10);
    push_exp("discard_commit", 8'h40);
    pulse_frame();
    check_pop();
    push_exp("discard_clr", 8'h00);
    send_byte(8'h11);
    check_pop();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h02); send_byte(8'h03); send_byte(8'h10);
    cur.ov = 2'd2; cur.sc = 2'd3;
    push_exp("ov_sc", 8'h00);
    pulse_frame();
    check_pop();

    // commit coinciding with frame_start waits for the next frame
    send_byte(8'h07); send_byte(8'h00); send_byte(8'h05);
    push_exp("commit_on_frame", 8'h80);
    rx_valid = 1'b1; rx_data = 8'h10; frame_start = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; frame_start = 1'b0;
    check_pop();
    cur.ct = 15'd5;
    push_exp("commit_next_frame", 8'h00);
    pulse_frame();
    check_pop();

    // shadow write coinciding with apply: old shadow value is copied
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h07); send_byte(8'h10);
    send_byte(8'h08); send_byte(8'h00);
    cur.cb = 15'd7;
    push_exp("write_on_apply", 8'h00);
    rx_valid = 1'b1; rx_data = 8'h09; frame_start = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; frame_start = 1'b0;
    check_pop();
    send_byte(8'h10);
    cur.cb = 15'd9;
    push_exp("write_later_commit", 8'h00);
    pulse_frame();
    check_pop();

    // byte coinciding with cs_end is dropped, command incomplete
    send_byte(8'h01);
    push_exp("byte_with_cs", 8'h40);
    rx_valid = 1'b1; rx_data = 8'h03; cs_end = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; cs_end = 1'b0;
    check_pop();
    send_byte(8'h11); send_byte(8'h10);
    push_exp("byte_with_cs_commit", 8'h00);
    pulse_frame();
    check_pop();

    // no pending commit -> no change; repeated commits collapse
    send_byte(8'h03); send_byte(8'h80); send_byte(8'h00);
    push_exp("frame_no_commit", 8'h00);
    pulse_frame();
    check_pop();
    push_exp("double_commit", 8'h80);
    send_byte(8'h10); send_byte(8'h10);
    check_pop();
    cur.ox = 16'h8000;
    push_exp("double_commit_apply", 8'h00);
    pulse_frame();
    check_pop();
    push_exp("double_commit_once", 8'h00);
    pulse_frame();
    check_pop();

    // reset with pending commit discards everything
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h2C); send_byte(8'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur = '{tag: "", ov: 2'd0, sc: 2'd0, ox: 16'd0, oy: 16'd0,
            cl: 15'd0, cr: 15'd0, ct: 15'd0, cb: 15'd0, st: 8'h00};
    push_exp("mid_reset", 8'h00);
    check_pop();
    push_exp("post_reset_frame", 8'h00);
    pulse_frame();
    check_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
